// File: rtl/pipe_stage_buffer.sv
// pipe_stage_buffer: elastic pipeline-stage register.
// A DEPTH-entry circular buffer carrying one packed stage payload between two
// pipeline stages. It uses a valid/ready handshake on both sides, a synchronous
// flush that kills buffered and incoming payloads, and drives a bubble when empty.
module pipe_stage_buffer #(
  parameter int               WIDTH         = 64,
  parameter int               DEPTH         = 2,
  parameter logic [WIDTH-1:0] BUBBLE        = '0,
  parameter bit               KEEP_ON_EMPTY = 1'b0
) (
  input  logic                       i_clock,
  input  logic                       i_reset,
  input  logic                       i_flush,
  input  logic                       i_in_valid,
  input  logic [WIDTH-1:0]           i_in_data,
  output logic                       o_in_ready,
  output logic                       o_out_valid,
  output logic [WIDTH-1:0]           o_out_data,
  input  logic                       i_out_ready,
  output logic [$clog2(DEPTH+1)-1:0] o_count
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = $clog2(DEPTH + 1);

  localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(DEPTH - 1);
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

  // Payload storage and bookkeeping.
  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [PTR_W-1:0] r_head;
  logic [PTR_W-1:0] r_tail;
  logic [CNT_W-1:0] r_count;
  logic [WIDTH-1:0] r_last;

  logic             w_push;
  logic             w_pop;
  logic [PTR_W-1:0] w_head_nxt;
  logic [PTR_W-1:0] w_tail_nxt;

  // Pointer advance that wraps at DEPTH-1, so DEPTH need not be a power of 2.
  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == LAST_PTR) ? '0 : p + 1'b1;
  endfunction

  // Handshake decode. in_ready depends on occupancy only, so there is no
  // combinational path from out_ready back to in_ready.
  assign o_in_ready  = (r_count < FULL_CNT);
  assign o_out_valid = (r_count != '0);
  assign w_push      = i_in_valid  & o_in_ready  & ~i_flush;
  assign w_pop       = o_out_valid & i_out_ready & ~i_flush;
  assign w_head_nxt  = ptr_inc(r_head);
  assign w_tail_nxt  = ptr_inc(r_tail);
  assign o_count     = r_count;

  // Pointer, occupancy and last-popped state; reset beats flush, flush beats push/pop.
  always_ff @(posedge i_clock) begin
    // NOTE: non-blocking assignments keep every register sampling pre-edge values,
    // so head/tail/count updates never see each other's new value in the same edge.
    if (i_reset) begin
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
      r_last  <= BUBBLE;
    end else if (i_flush) begin
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
      r_last  <= BUBBLE;
    end else begin
      if (w_push) r_tail <= w_tail_nxt;
      if (w_pop) begin
        r_head <= w_head_nxt;
        r_last <= r_mem[r_head];
      end
      unique case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  // Payload write into the tail slot.
  always_ff @(posedge i_clock) begin
    // NOTE: the storage array is deliberately not reset; entries are only ever
    // observed when count says they are valid, so stale contents are harmless.
    if (w_push) r_mem[r_tail] <= i_in_data;
  end

  // Output mux: head entry when occupied, otherwise bubble or the last popped payload.
  always_comb begin
    // NOTE: assigning a default first guarantees no latch is inferred.
    o_out_data = BUBBLE;
    if (r_count != '0)      o_out_data = r_mem[r_head];
    else if (KEEP_ON_EMPTY) o_out_data = r_last;
  end

endmodule

// File: tb/tb_pipe_stage_buffer.sv
// Directed self-checking bench for pipe_stage_buffer.
// Three instances share clock and reset: A (DEPTH=2), B (DEPTH=3, wrap test),
// C (DEPTH=2, KEEP_ON_EMPTY=1). Inputs change 1 time unit after the rising edge
// and outputs are sampled there too, well away from the edge.
module tb_pipe_stage_buffer;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Instance A: WIDTH=8, DEPTH=2, BUBBLE=00, KEEP_ON_EMPTY=0
  logic       a_flush = 0, a_in_valid = 0, a_out_ready = 0;
  logic [7:0] a_in_data = '0;
  logic       a_in_ready, a_out_valid;
  logic [7:0] a_out_data;
  logic [1:0] a_count;

  pipe_stage_buffer #(.WIDTH(8), .DEPTH(2), .BUBBLE(8'h00), .KEEP_ON_EMPTY(1'b0)) u_a (
    .i_clock(clk), .i_reset(rst), .i_flush(a_flush),
    .i_in_valid(a_in_valid), .i_in_data(a_in_data), .o_in_ready(a_in_ready),
    .o_out_valid(a_out_valid), .o_out_data(a_out_data), .i_out_ready(a_out_ready),
    .o_count(a_count));

  // Instance B: WIDTH=8, DEPTH=3
  logic       b_flush = 0, b_in_valid = 0, b_out_ready = 0;
  logic [7:0] b_in_data = '0;
  logic       b_in_ready, b_out_valid;
  logic [7:0] b_out_data;
  logic [1:0] b_count;

  pipe_stage_buffer #(.WIDTH(8), .DEPTH(3), .BUBBLE(8'h00), .KEEP_ON_EMPTY(1'b0)) u_b (
    .i_clock(clk), .i_reset(rst), .i_flush(b_flush),
    .i_in_valid(b_in_valid), .i_in_data(b_in_data), .o_in_ready(b_in_ready),
    .o_out_valid(b_out_valid), .o_out_data(b_out_data), .i_out_ready(b_out_ready),
    .o_count(b_count));

  // Instance C: WIDTH=8, DEPTH=2, KEEP_ON_EMPTY=1
  logic       c_flush = 0, c_in_valid = 0, c_out_ready = 0;
  logic [7:0] c_in_data = '0;
  logic       c_in_ready, c_out_valid;
  logic [7:0] c_out_data;
  logic [1:0] c_count;

  pipe_stage_buffer #(.WIDTH(8), .DEPTH(2), .BUBBLE(8'h00), .KEEP_ON_EMPTY(1'b1)) u_c (
    .i_clock(clk), .i_reset(rst), .i_flush(c_flush),
    .i_in_valid(c_in_valid), .i_in_data(c_in_data), .o_in_ready(c_in_ready),
    .o_out_valid(c_out_valid), .o_out_data(c_out_data), .i_out_ready(c_out_ready),
    .o_count(c_count));

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Advance one clock and settle 1 time unit past the edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  logic [31:0] pat;
  int sent, rcvd, first_cyc, last_cyc;

  initial begin
    // ---------------- reset ----------------
    step(); step();
    rst = 1'b0;
    check("rst_count",     a_count,     0);
    check("rst_out_valid", a_out_valid, 0);
    check("rst_out_data",  a_out_data,  8'h00);
    check("rst_in_ready",  a_in_ready,  1);
    check("rst_c_data",    c_out_data,  8'h00);

    // ---------------- 1: single push, consumer stalled ----------------
    a_in_valid = 1; a_in_data = 8'hA1; a_out_ready = 0;
    check("t1_no_bypass", a_out_valid, 0);
    step();
    check("t1_out_valid", a_out_valid, 1);
    check("t1_out_data",  a_out_data,  8'hA1);
    check("t1_count",     a_count,     1);
    check("t1_in_ready",  a_in_ready,  1);

    // ---------------- 2: fill, then hold A3 while full ----------------
    a_in_data = 8'hA2;
    step();
    check("t2_count_full", a_count,    2);
    check("t2_in_ready",   a_in_ready, 0);
    check("t2_head",       a_out_data, 8'hA1);
    a_in_data = 8'hA3;
    step();
    check("t2_hold_count", a_count,    2);
    check("t2_hold_head",  a_out_data, 8'hA1);
    a_in_valid = 0; a_out_ready = 1;
    check("t2_ready_still_low", a_in_ready, 0);
    step();
    check("t2_pop1_data",   a_out_data, 8'hA2);
    check("t2_pop1_count",  a_count,    1);
    check("t2_ready_freed", a_in_ready, 1);
    step();
    check("t2_drained_valid", a_out_valid, 0);
    check("t2_drained_data",  a_out_data,  8'h00);
    a_out_ready = 0;

    // ---------------- 3: stream 01..10 with out_ready=1 ----------------
    sent = 1; rcvd = 1; first_cyc = -1; last_cyc = -1;
    for (int cyc = 0; cyc < 100; cyc++) begin
      a_in_valid  = (sent <= 16);
      a_in_data   = 8'(sent);
      a_out_ready = 1;
      if (a_out_valid) begin
        check("t3_order", a_out_data, rcvd);
        rcvd++;
        if (first_cyc < 0) first_cyc = cyc;
        last_cyc = cyc;
      end
      if (a_in_valid && a_in_ready) sent++;
      step();
      if (rcvd > 16) break;
    end
    a_in_valid = 0; a_out_ready = 0;
    check("t3_all_received", rcvd,                17);
    check("t3_fill_latency", first_cyc,           1);
    check("t3_throughput",   last_cyc - first_cyc, 15);
    check("t3_empty_after",  a_count,             0);

    // ---------------- 4: flush with B3 offered and out_ready=1 ----------------
    a_in_valid = 1; a_in_data = 8'hB1;
    step();
    a_in_data = 8'hB2;
    step();
    check("t4_count_pre", a_count, 2);
    a_flush = 1; a_in_data = 8'hB3; a_out_ready = 1;
    step();
    a_flush = 0; a_in_valid = 0;
    check("t4_count",     a_count,     0);
    check("t4_out_valid", a_out_valid, 0);
    check("t4_out_data",  a_out_data,  8'h00);
    check("t4_in_ready",  a_in_ready,  1);
    step();
    check("t4_stays_empty", a_out_valid, 0);
    a_in_valid = 1; a_in_data = 8'hD4; a_out_ready = 0;
    step();
    a_in_valid = 0;
    check("t4_repush_data",  a_out_data, 8'hD4);
    check("t4_repush_count", a_count,    1);

    // ---------------- 5: DEPTH=3 wrap with irregular out_ready ----------------
    pat = 32'hFFFF_F5A0;
    sent = 1; rcvd = 1;
    for (int cyc = 0; cyc < 32; cyc++) begin
      b_in_valid  = (sent <= 7);
      b_in_data   = 8'h30 + 8'(sent);
      b_out_ready = pat[cyc];
      check("t5_count_max", (b_count <= 2'd3) && (b_in_ready == (b_count != 2'd3)), 1);
      if (b_out_valid && b_out_ready) begin
        check("t5_order", b_out_data, 8'h30 + rcvd);
        rcvd++;
      end
      if (b_in_valid && b_in_ready) sent++;
      step();
      if (rcvd > 7) break;
    end
    b_in_valid = 0; b_out_ready = 0;
    check("t5_all_received", rcvd,    8);
    check("t5_empty_after",  b_count, 0);

    // ---------------- 6: KEEP_ON_EMPTY ----------------
    c_in_valid = 1; c_in_data = 8'hC5; c_out_ready = 0;
    step();
    c_in_valid = 0;
    check("t6_head", c_out_data, 8'hC5);
    c_out_ready = 1;
    step();
    c_out_ready = 0;
    check("t6_valid_low", c_out_valid, 0);
    check("t6_keep_data", c_out_data,  8'hC5);
    step();
    check("t6_keep_hold", c_out_data, 8'hC5);
    c_flush = 1;
    step();
    c_flush = 0;
    check("t6_flush_data", c_out_data, 8'h00);
    c_in_valid = 1; c_in_data = 8'hE7;
    step();
    c_in_valid = 0;
    check("t6_mid_count", c_count,    1);
    check("t6_mid_data",  c_out_data, 8'hE7);
    rst = 1;
    step();
    rst = 0;
    check("t6_rst_count", c_count,     0);
    check("t6_rst_valid", c_out_valid, 0);
    check("t6_rst_data",  c_out_data,  8'h00);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
